subfp8_issue_ctrl: RTL and testbench

Issue and writeback controller for the custom sub-FP8 arithmetic datapath (`riscv::OpcodeCustomArithmeticSubFp`).
- Sits between the issue stage and two execution resources: a fixed-latency pipelined sub-FP8 unit and a multi-cycle iterative divider.
- Decodes the instruction word into a 4-bit op code, dispatches operands, and tracks transaction IDs through the pipelined unit.
- Sequences the divider with a small FSM and merges both result sources onto one registered writeback port. Flushes are handled without draining.

---
 rtl/subfp8_issue_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_subfp8_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subfp8_issue_ctrl.sv
// -----------------------------------------------------------------------------
// subfp8_issue_ctrl
//
// Issue and writeback controller for the custom sub-FP8 arithmetic datapath.
// Decodes the instruction word into a 4-bit op code, dispatches operands to a
// fixed-latency pipelined sub-FP8 unit, tracks transaction IDs through that
// unit, sequences an optional iterative divider and merges both result
// sources onto one registered writeback port. Flushes kill in-flight work
// without draining.
//
// Configuration macro: SUBFP8_DIV_EN
//   defined   : DIV (funct7 0000011) goes to the divider through a small FSM
//   undefined : DIV decodes as illegal, divider ports are tied off / ignored
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  kill all in-flight work
//   valid_i / ready_o        issue handshake
//   instr_i, trans_id_i      instruction word and its transaction ID
//   operand_a_i/operand_b_i  sub-FP8 operands
//   pipe_valid_o, pipe_op_o,
//   pipe_a_o, pipe_b_o       dispatch to the pipelined unit
//   pipe_valid_i,
//   pipe_result_i            pipelined unit result (PIPE_LAT after dispatch)
//   div_start_o, div_kill_o  divider start / abort pulses
//   div_done_i, div_result_i divider completion pulse and result
//   result_valid_o, result_o,
//   result_trans_id_o,
//   exception_o              registered writeback port
//
// Handshake: a request transfers in any cycle where valid_i and ready_o are
// both high (accept = valid_i & ready_o); the controller raises ready_o only
// while idle and not flushing, so it never needs to hold a request.
// -----------------------------------------------------------------------------
module subfp8_issue_ctrl #(
    parameter int         TRANS_ID_BITS = 3,
    parameter int         PIPE_LAT      = 2,
    parameter logic [6:0] OPCODE_SUBFP  = 7'b0001011
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [31:0]              instr_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [7:0]               operand_a_i,
    input  logic [7:0]               operand_b_i,
    output logic                     pipe_valid_o,
    output logic [3:0]               pipe_op_o,
    output logic [7:0]               pipe_a_o,
    output logic [7:0]               pipe_b_o,
    input  logic                     pipe_valid_i,
    input  logic [7:0]               pipe_result_i,
    output logic                     div_start_o,
    output logic                     div_kill_o,
    input  logic                     div_done_i,
    input  logic [7:0]               div_result_i,
    output logic                     result_valid_o,
    output logic [7:0]               result_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
    output logic                     exception_o
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
`ifdef SUBFP8_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'd3;
`endif
    localparam logic [3:0] OP_MIN   = 4'd4;
    localparam logic [3:0] OP_MAX   = 4'd5;
    localparam logic [3:0] OP_CVT   = 4'd6;
    localparam logic [3:0] OP_SGNJ  = 4'd7;
    localparam logic [3:0] OP_SGNJN = 4'd8;
    localparam logic [3:0] OP_SGNJX = 4'd9;
    localparam logic [3:0] OP_MVXB  = 4'd10;
    localparam logic [3:0] OP_MVBX  = 4'd11;
    localparam logic [3:0] OP_CLASS = 4'd12;
    localparam logic [3:0] OP_EQ    = 4'd13;
    localparam logic [3:0] OP_LT    = 4'd14;
    localparam logic [3:0] OP_LE    = 4'd15;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] dec_op;
    logic       dec_legal;
    logic       dec_is_div;

    assign funct7 = instr_i[31:25];
    assign rs2    = instr_i[24:20];
    assign funct3 = instr_i[14:12];
    assign rd     = instr_i[11:7];

    always_comb begin
        dec_op    = OP_ADD;
        dec_legal = 1'b0;
        if (instr_i[6:0] == OPCODE_SUBFP) begin
            case (funct7)
                7'b0000000: begin dec_op = OP_ADD; dec_legal = 1'b1; end
                7'b0000001: begin dec_op = OP_SUB; dec_legal = 1'b1; end
                7'b0000010: begin dec_op = OP_MUL; dec_legal = 1'b1; end
`ifdef SUBFP8_DIV_EN
                7'b0000011: begin dec_op = OP_DIV; dec_legal = 1'b1; end
`endif
                7'b0000100: begin
                    if (funct3 == 3'b000) begin
                        dec_op = OP_MIN; dec_legal = 1'b1;
                    end else if (funct3 == 3'b001) begin
                        dec_op = OP_MAX; dec_legal = 1'b1;
                    end
                end
                7'b0000101: begin
                    if (rs2 == 5'd0) begin
                        dec_op = OP_CVT; dec_legal = 1'b1;
                    end
                end
                7'b0001010: begin
                    case (funct3)
                        3'b000:  begin dec_op = OP_SGNJ;  dec_legal = 1'b1; end
                        3'b001:  begin dec_op = OP_SGNJN; dec_legal = 1'b1; end
                        3'b010:  begin dec_op = OP_SGNJX; dec_legal = 1'b1; end
                        default: ;
                    endcase
                end
                7'b0000111: begin
                    if (rs2 == 5'd0) begin
                        if (funct3 == 3'b000) begin
                            dec_op = OP_MVXB; dec_legal = 1'b1;
                        end else if (funct3 == 3'b001) begin
                            dec_op = OP_CLASS; dec_legal = 1'b1;
                        end
                    end
                end
                7'b0001000: begin
                    if (rs2 == 5'd0 && funct3 == 3'b000) begin
                        dec_op = OP_MVBX; dec_legal = 1'b1;
                    end
                end
                // Compares select their flavour through the rd field.
                7'b0001011: begin
                    case (rd)
                        5'b00010: begin dec_op = OP_EQ; dec_legal = 1'b1; end
                        5'b00001: begin dec_op = OP_LT; dec_legal = 1'b1; end
                        5'b00000: begin dec_op = OP_LE; dec_legal = 1'b1; end
                        default:  ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef SUBFP8_DIV_EN
    assign dec_is_div = dec_legal & (dec_op == OP_DIV);
`else
    assign dec_is_div = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Issue handshake and dispatch
    // ------------------------------------------------------------------
    logic accept;
    logic operand_drive;

    assign accept       = valid_i & ready_o;
    assign pipe_valid_o = accept & dec_legal & ~dec_is_div;

    // Operand/op buses are quiet unless something is actually dispatched; the
    // divider samples the same operand buses together with its start pulse.
    assign operand_drive = pipe_valid_o | div_start_o;
    assign pipe_op_o     = operand_drive ? dec_op      : 4'd0;
    assign pipe_a_o      = operand_drive ? operand_a_i : 8'd0;
    assign pipe_b_o      = operand_drive ? operand_b_i : 8'd0;

    // ------------------------------------------------------------------
    // Tracking shift register: one slot per pipeline stage. Illegal ops ride
    // along so they retire in order with the same latency as real ops.
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0]                    trk_valid;
    logic [PIPE_LAT-1:0]                    trk_ill;
    logic [PIPE_LAT-1:0][TRANS_ID_BITS-1:0] trk_id;
    logic                                   head_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_valid <= '0;
            trk_ill   <= '0;
            trk_id    <= '0;
        end else begin
            // accept is already low while flushing
            trk_valid[0] <= accept & ~dec_is_div;
            trk_ill[0]   <= ~dec_legal;
            trk_id[0]    <= trans_id_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                trk_valid[i] <= trk_valid[i-1] & ~flush_i;
                trk_ill[i]   <= trk_ill[i-1];
                trk_id[i]    <= trk_id[i-1];
            end
        end
    end

    // A flush also kills the entry that would retire in the flush cycle.
    assign head_valid = trk_valid[PIPE_LAT-1] & ~flush_i;

    // ------------------------------------------------------------------
    // Writeback arbitration (pipe head always wins) and divider FSM
    // ------------------------------------------------------------------
    logic                     wb_fire;
    logic [7:0]               wb_data;
    logic [TRANS_ID_BITS-1:0] wb_id;
    logic                     wb_exc;

`ifdef SUBFP8_DIV_EN
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DIV_BUSY = 2'd1;
    localparam logic [1:0] ST_DIV_DONE = 2'd2;

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [TRANS_ID_BITS-1:0] div_id_q;
    logic [7:0]               div_res_q;

    assign ready_o     = (state_q == ST_IDLE) & ~flush_i;
    assign div_start_o = accept & dec_is_div;
    assign div_kill_o  = flush_i & (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (div_start_o) state_d = ST_DIV_BUSY;
            end
            ST_DIV_BUSY: begin
                if (flush_i)         state_d = ST_IDLE;
                else if (div_done_i) state_d = head_valid ? ST_DIV_DONE : ST_IDLE;
            end
            ST_DIV_DONE: begin
                if (flush_i || !head_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            div_id_q  <= '0;
            div_res_q <= '0;
        end else begin
            state_q <= state_d;
            if (div_start_o) div_id_q <= trans_id_i;
            // Divider finished while the pipe owns the slot: park the result.
            if (state_q == ST_DIV_BUSY && div_done_i && head_valid) div_res_q <= div_result_i;
        end
    end
`else
    logic unused_div_inputs;

    assign unused_div_inputs = ^{div_done_i, div_result_i};
    assign ready_o           = ~flush_i;
    assign div_start_o       = 1'b0;
    assign div_kill_o        = 1'b0;
`endif

    always_comb begin
        wb_fire = 1'b0;
        wb_data = 8'd0;
        wb_id   = '0;
        wb_exc  = 1'b0;
        if (head_valid) begin
            wb_fire = 1'b1;
            wb_id   = trk_id[PIPE_LAT-1];
            wb_exc  = trk_ill[PIPE_LAT-1];
            wb_data = trk_ill[PIPE_LAT-1] ? 8'd0 : pipe_result_i;
        end
`ifdef SUBFP8_DIV_EN
        else if (state_q == ST_DIV_BUSY && div_done_i && !flush_i) begin
            wb_fire = 1'b1;
            wb_id   = div_id_q;
            wb_data = div_result_i;
        end else if (state_q == ST_DIV_DONE && !flush_i) begin
            wb_fire = 1'b1;
            wb_id   = div_id_q;
            wb_data = div_res_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_o    <= 1'b0;
            result_o          <= 8'd0;
            result_trans_id_o <= '0;
            exception_o       <= 1'b0;
        end else begin
            result_valid_o    <= wb_fire;
            result_o          <= wb_data;
            result_trans_id_o <= wb_id;
            exception_o       <= wb_exc;
        end
    end

    // rs1 is consumed by the datapath's register read, not by this block.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[19:15];

`ifndef SYNTHESIS
    // Remember which slots were killed by a flush so their late pipe results
    // are recognised as expected discards rather than protocol errors.
    logic [PIPE_LAT-1:0] trk_stale;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_stale <= '0;
        end else begin
            trk_stale[0] <= 1'b0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                trk_stale[i] <= trk_stale[i-1] | (flush_i & trk_valid[i-1]);
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && pipe_valid_i) begin
            assert ((trk_valid[PIPE_LAT-1] && !trk_ill[PIPE_LAT-1]) || trk_stale[PIPE_LAT-1])
            else $error("subfp8_issue_ctrl: pipe result with no legal tracked op");
        end
    end
`endif

endmodule

// File: tb/tb_subfp8_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_subfp8_issue_ctrl
//
// Bench for subfp8_issue_ctrl: a decode vector table issued back to back,
// hand sequences for flush and divider corner cases, a behavioural model of
// the pipelined unit, and a writeback scoreboard checking value and cycle.
// Build with SUBFP8_DIV_EN defined to also exercise the divider path.
// -----------------------------------------------------------------------------
module tb_subfp8_issue_ctrl;

  localparam int         TID = 3;
  localparam int         LAT = 2;
  localparam int         W   = 1 + TID + 8;
  localparam logic [6:0] OPC = 7'b0001011;

  // ---------------- clock / reset ----------------
  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic [31:0]    instr_i = '0;
  logic [TID-1:0] trans_id_i = '0;
  logic [7:0]     operand_a_i = '0;
  logic [7:0]     operand_b_i = '0;
  logic           pipe_valid_o;
  logic [3:0]     pipe_op_o;
  logic [7:0]     pipe_a_o;
  logic [7:0]     pipe_b_o;
  logic           pipe_valid_i = 1'b0;
  logic [7:0]     pipe_result_i = '0;
  logic           div_start_o;
  logic           div_kill_o;
  logic           div_done_i = 1'b0;
  logic [7:0]     div_result_i = '0;
  logic           result_valid_o;
  logic [7:0]     result_o;
  logic [TID-1:0] result_trans_id_o;
  logic           exception_o;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  subfp8_issue_ctrl #(.TRANS_ID_BITS(TID), .PIPE_LAT(LAT), .OPCODE_SUBFP(OPC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i), .trans_id_i(trans_id_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .pipe_valid_o(pipe_valid_o), .pipe_op_o(pipe_op_o), .pipe_a_o(pipe_a_o), .pipe_b_o(pipe_b_o),
    .pipe_valid_i(pipe_valid_i), .pipe_result_i(pipe_result_i),
    .div_start_o(div_start_o), .div_kill_o(div_kill_o),
    .div_done_i(div_done_i), .div_result_i(div_result_i),
    .result_valid_o(result_valid_o), .result_o(result_o),
    .result_trans_id_o(result_trans_id_o), .exception_o(exception_o)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behaviour of the pipelined unit the controller feeds.
  function automatic logic [7:0] pipe_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    return a + b + {4'd0, op};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {f7, rs2, 5'd1, f3, rd, opc};
  endfunction

  // ---------------- pipelined unit model ----------------
  int         pm_due_q[$];
  logic [7:0] pm_res_q[$];

  always @(negedge clk_i) begin
    if (rst_ni && pipe_valid_o) begin
      pm_due_q.push_back(cyc + LAT);
      pm_res_q.push_back(pipe_fn(pipe_op_o, pipe_a_o, pipe_b_o));
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (pm_due_q.size() > 0 && pm_due_q[0] == cyc) begin
      pipe_valid_i  = 1'b1;
      pipe_result_i = pm_res_q[0];
      void'(pm_due_q.pop_front());
      void'(pm_res_q.pop_front());
    end else begin
      pipe_valid_i  = 1'b0;
      pipe_result_i = 8'd0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  always @(negedge clk_i) begin
    if (rst_ni && result_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=%0h required=none (cycle %0d)",
                 {exception_o, result_trans_id_o, result_o}, cyc);
      end else begin
        chk("wb_data", {20'd0, exception_o, result_trans_id_o, result_o}, {20'd0, exp_q[0]});
        chk("wb_cycle", cyc, exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i    = 1'b0;
    flush_i    = 1'b0;
    div_done_i = 1'b0;
    step();
  endtask

  // Drives one request for a cycle (valid_i left high for back-to-back use).
  task automatic issue(input logic [31:0] instr, input logic [7:0] a, input logic [7:0] b,
                       input logic [TID-1:0] id, input logic legal, input logic [3:0] op,
                       input logic is_div, input logic want_wb);
    logic [W-1:0] e;
    valid_i = 1'b1; instr_i = instr; trans_id_i = id; operand_a_i = a; operand_b_i = b;
    @(negedge clk_i);
    chk("issue_ready", ready_o, 1);
    chk("pipe_valid", pipe_valid_o, legal & ~is_div);
    chk("div_start", div_start_o, legal & is_div);
    if (!(legal && is_div)) begin
      chk("pipe_op", pipe_op_o, legal ? op : 4'd0);
      chk("pipe_a", pipe_a_o, legal ? a : 8'd0);
      chk("pipe_b", pipe_b_o, legal ? b : 8'd0);
      if (want_wb) begin
        e = {~legal, id, legal ? pipe_fn(op, a, b) : 8'h00};
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + LAT + 1);
      end
    end
    step();
  endtask

  task automatic flush_cycle();
    valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_ready", ready_o, 0);
    step();
    flush_i = 1'b0;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic [3:0]  op;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] instr, input logic legal, input logic [3:0] op);
    vec_t v;
    v.instr = instr; v.legal = legal; v.op = op;
    vecs.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] add_i;
    logic [31:0] div_i;
    add_i = mk(7'b0000000, 5'd2, 3'b000, 5'd3, OPC);
    div_i = mk(7'b0000011, 5'd2, 3'b000, 5'd3, OPC);

    add_vec(mk(7'b0000010, 5'd2, 3'b000, 5'd3,     OPC), 1, 4'd2);   // MUL
    add_vec(mk(7'b0000100, 5'd2, 3'b000, 5'd3,     OPC), 1, 4'd4);   // MIN
    add_vec(mk(7'b0001010, 5'd2, 3'b010, 5'd3,     OPC), 1, 4'd9);   // SGNJX
    add_vec(mk(7'b0001011, 5'd2, 3'b000, 5'b00010, OPC), 1, 4'd13);  // EQ
    add_vec(mk(7'b0000001, 5'd2, 3'b000, 5'd3,     OPC), 1, 4'd1);   // SUB
    add_vec(mk(7'b0000100, 5'd2, 3'b001, 5'd3,     OPC), 1, 4'd5);   // MAX
    add_vec(mk(7'b0000100, 5'd2, 3'b010, 5'd3,     OPC), 0, 4'd0);   // MIN bad f3
    add_vec(mk(7'b0000101, 5'd0, 3'b000, 5'd3,     OPC), 1, 4'd6);   // CVT
    add_vec(mk(7'b0000101, 5'd3, 3'b000, 5'd3,     OPC), 0, 4'd0);   // CVT rs2!=0
    add_vec(mk(7'b0001010, 5'd2, 3'b000, 5'd3,     OPC), 1, 4'd7);   // SGNJ
    add_vec(mk(7'b0001010, 5'd2, 3'b001, 5'd3,     OPC), 1, 4'd8);   // SGNJN
    add_vec(mk(7'b0001010, 5'd2, 3'b011, 5'd3,     OPC), 0, 4'd0);   // SGNJ bad f3
    add_vec(mk(7'b0000111, 5'd0, 3'b000, 5'd3,     OPC), 1, 4'd10);  // MVXB
    add_vec(mk(7'b0000111, 5'd0, 3'b001, 5'd3,     OPC), 1, 4'd12);  // CLASS
    add_vec(mk(7'b0000111, 5'd0, 3'b010, 5'd3,     OPC), 0, 4'd0);
    add_vec(mk(7'b0000111, 5'd1, 3'b000, 5'd3,     OPC), 0, 4'd0);
    add_vec(mk(7'b0001000, 5'd0, 3'b000, 5'd3,     OPC), 1, 4'd11);  // MVBX
    add_vec(mk(7'b0001000, 5'd0, 3'b001, 5'd3,     OPC), 0, 4'd0);
    add_vec(mk(7'b0001011, 5'd2, 3'b000, 5'b00001, OPC), 1, 4'd14);  // LT
    add_vec(mk(7'b0001011, 5'd2, 3'b000, 5'b00000, OPC), 1, 4'd15);  // LE
    add_vec(mk(7'b0001011, 5'd2, 3'b000, 5'b00011, OPC), 0, 4'd0);
    add_vec(mk(7'b0000000, 5'd2, 3'b111, 5'd3,     OPC), 1, 4'd0);   // ADD, any f3
    add_vec(mk(7'b0000000, 5'd2, 3'b000, 5'd3, 7'b0110011), 0, 4'd0); // wrong opcode
    add_vec(mk(7'b1111111, 5'd2, 3'b000, 5'd3,     OPC), 0, 4'd0);
`ifndef SUBFP8_DIV_EN
    add_vec(div_i, 0, 4'd0);                                          // DIV disabled
`endif

    // reset
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    chk("rst_pipe_valid", pipe_valid_o, 0);
    chk("rst_pipe_op", pipe_op_o, 0);
    chk("rst_div_start", div_start_o, 0);
    chk("rst_div_kill", div_kill_o, 0);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_result", {exception_o, result_trans_id_o, result_o}, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle();

    // single ADD: 0x1E + 0x1E through the unit returns 0x3C, ID 5
    issue(add_i, 8'h1E, 8'h1E, 3'd5, 1, 4'd0, 0, 1);
    repeat (5) idle();

    // table issued back to back
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].instr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            TID'((i + 1) % 8), vecs[i].legal, vecs[i].op, 0, 1);
    end
    repeat (6) idle();

    // illegal funct7 with ID 2
    issue(mk(7'b1111111, 5'd2, 3'b000, 5'd3, OPC), 8'h12, 8'h34, 3'd2, 0, 4'd0, 0, 1);
    repeat (5) idle();

    // flush one cycle after issue; request during flush is refused
    issue(add_i, 8'h01, 8'h02, 3'd1, 1, 4'd0, 0, 0);
    flush_i = 1'b1; valid_i = 1'b1; instr_i = add_i; trans_id_i = 3'd2;
    @(negedge clk_i);
    chk("flush1_ready", ready_o, 0);
    chk("flush1_pipe_valid", pipe_valid_o, 0);
    chk("flush1_div_kill", div_kill_o, 0);
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush1_ready_after", ready_o, 1);
    step();
    repeat (4) idle();

    // flush in the head cycle kills the writeback
    issue(add_i, 8'h05, 8'h06, 3'd3, 1, 4'd0, 0, 0);
    idle();
    flush_cycle();
    repeat (4) idle();

    // flush after the writeback registered: it is still presented
    issue(add_i, 8'h07, 8'h08, 3'd4, 1, 4'd0, 0, 1);
    idle();
    idle();
    flush_cycle();
    repeat (4) idle();

`ifdef SUBFP8_DIV_EN
    // simple divide, slot free
    issue(div_i, 8'h40, 8'h02, 3'd6, 1, 4'd3, 1, 0);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("div_ready_busy", ready_o, 0);
    chk("div_start_pulse", div_start_o, 0);
    step();
    step();
    div_done_i = 1'b1; div_result_i = 8'h55;
    exp_q.push_back({1'b0, 3'd6, 8'h55});
    exp_cyc_q.push_back(cyc + 1);
    step();
    repeat (5) idle();

    // divide completing against an ADD head
    issue(add_i, 8'h10, 8'h20, 3'd7, 1, 4'd0, 0, 1);
    issue(div_i, 8'h30, 8'h03, 3'd6, 1, 4'd3, 1, 0);
    valid_i = 1'b0;
    div_done_i = 1'b1; div_result_i = 8'h77;
    exp_q.push_back({1'b0, 3'd6, 8'h77});
    exp_cyc_q.push_back(cyc + 2);
    @(negedge clk_i);
    chk("coll_ready_t1", ready_o, 0);
    step();
    div_done_i = 1'b0;
    @(negedge clk_i);
    chk("coll_ready_t2", ready_o, 0);
    step();
    repeat (5) idle();

    // flush with divide in flight
    issue(div_i, 8'h11, 8'h22, 3'd3, 1, 4'd3, 1, 0);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("dflush_kill_early", div_kill_o, 0);
    step();
    flush_i = 1'b1; valid_i = 1'b1; instr_i = add_i; trans_id_i = 3'd5;
    @(negedge clk_i);
    chk("dflush_kill", div_kill_o, 1);
    chk("dflush_ready", ready_o, 0);
    chk("dflush_pipe_valid", pipe_valid_o, 0);
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    chk("dflush_ready_after", ready_o, 1);
    chk("dflush_kill_pulse", div_kill_o, 0);
    step();
    div_done_i = 1'b1; div_result_i = 8'h99;
    step();
    repeat (5) idle();
`endif

    // drain, bounded
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
